// File: rtl/imm_decode_pipe.sv
// -----------------------------------------------------------------------------
// imm_decode_pipe
//   Pipelined RV32/RV64 immediate extractor sitting between fetch and execute.
//   Decodes I/S/B/U/J immediates, shift amounts and the CSR zimm field. The
//   format is taken from the opcode/funct3 (AUTO_DECODE=1) or from type_i
//   (AUTO_DECODE=0). A 2-entry buffer (OUT + SKID) gives one cycle of latency
//   with fully registered valid/ready on both sides.
//
//   State table
//     state   | meaning
//     S_EMPTY | nothing buffered, out_valid_o=0
//     S_ONE   | OUT slot holds a word, SKID empty
//     S_FULL  | OUT and SKID both hold a word, in_ready_o=0
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous, active-high reset
//   flush_i      drop all buffered entries (branch redirect)
//   in_valid_i   inst_i/type_i valid
//   in_ready_o   block can accept a word (registered)
//   inst_i       raw 32-bit instruction word
//   type_i       format when AUTO_DECODE=0 (0 NONE,1 I,2 S,3 B,4 U,5 J,
//                6 SHAMT,7 ZIMM)
//   out_valid_o  imm_o/imm_type_o/illegal_o valid
//   out_ready_i  consumer accepts the current output
//   imm_o        extended immediate, XLEN bits
//   imm_type_o   format used, same encoding as type_i
//   illegal_o    no immediate format matched; imm_o is zero
// -----------------------------------------------------------------------------
module imm_decode_pipe #(
    parameter int XLEN        = 32,   // 32 or 64 only
    parameter bit AUTO_DECODE = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     inst_i,
    input  logic [2:0]      type_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      imm_type_o,
    output logic            illegal_o
);

    localparam logic [2:0] T_NONE  = 3'd0;
    localparam logic [2:0] T_I     = 3'd1;
    localparam logic [2:0] T_S     = 3'd2;
    localparam logic [2:0] T_B     = 3'd3;
    localparam logic [2:0] T_U     = 3'd4;
    localparam logic [2:0] T_J     = 3'd5;
    localparam logic [2:0] T_SHAMT = 3'd6;
    localparam logic [2:0] T_ZIMM  = 3'd7;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            sgn;
    logic [5:0]      shamt;
    logic [2:0]      auto_type;
    logic [2:0]      dec_type_d;
    logic [XLEN-1:0] dec_imm_d;
    logic            dec_ill_d;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign sgn    = inst_i[31];
    // RV64 shifts use a 6-bit shamt; RV32 only 5 bits.
    assign shamt  = (XLEN == 64) ? inst_i[25:20] : {1'b0, inst_i[24:20]};

    always_comb begin
        auto_type = T_NONE;
        case (opcode)
            7'b0010011: auto_type = (funct3[1:0] == 2'b01) ? T_SHAMT : T_I;
            7'b0000011,
            7'b1100111,
            7'b0001111: auto_type = T_I;
            7'b0100011: auto_type = T_S;
            7'b1100011: auto_type = T_B;
            7'b0110111,
            7'b0010111: auto_type = T_U;
            7'b1101111: auto_type = T_J;
            7'b1110011: auto_type = funct3[2] ? T_ZIMM : T_I;
            default:    auto_type = T_NONE;
        endcase
    end

    always_comb begin
        dec_type_d = AUTO_DECODE ? auto_type : type_i;
        dec_imm_d  = '0;
        dec_ill_d  = 1'b0;
        case (dec_type_d)
            T_I:     dec_imm_d = {{(XLEN-12){sgn}}, inst_i[31:20]};
            T_S:     dec_imm_d = {{(XLEN-12){sgn}}, inst_i[31:25], inst_i[11:7]};
            T_B:     dec_imm_d = {{(XLEN-12){sgn}}, inst_i[7], inst_i[30:25],
                                  inst_i[11:8], 1'b0};
            // inst[31] is both the top U bit and the sign for RV64.
            T_U:     dec_imm_d = {{(XLEN-31){sgn}}, inst_i[30:12], 12'h000};
            T_J:     dec_imm_d = {{(XLEN-20){sgn}}, inst_i[19:12], inst_i[20],
                                  inst_i[30:21], 1'b0};
            T_SHAMT: dec_imm_d = {{(XLEN-6){1'b0}}, shamt};
            T_ZIMM:  dec_imm_d = {{(XLEN-5){1'b0}}, inst_i[19:15]};
            default: dec_ill_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Two-slot buffer and handshake FSM
    // ------------------------------------------------------------------
    state_t          state_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [XLEN-1:0] out_imm_q;
    logic [2:0]      out_type_q;
    logic            out_ill_q;
    logic [XLEN-1:0] skid_imm_q;
    logic [2:0]      skid_type_q;
    logic            skid_ill_q;

    logic accept;
    logic pop;

    assign accept = in_valid_i & in_ready_q;
    assign pop    = out_valid_q & out_ready_i;

    always_ff @(posedge clk_i) begin
        // Flush shares the reset path so it wins over any same-cycle
        // accept or pop.
        if (rst_i || flush_i) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_type_q  <= T_NONE;
            out_ill_q   <= 1'b0;
            skid_imm_q  <= '0;
            skid_type_q <= T_NONE;
            skid_ill_q  <= 1'b0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        out_imm_q   <= dec_imm_d;
                        out_type_q  <= dec_type_d;
                        out_ill_q   <= dec_ill_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && pop) begin
                        out_imm_q   <= dec_imm_d;
                        out_type_q  <= dec_type_d;
                        out_ill_q   <= dec_ill_d;
                    end else if (accept) begin
                        skid_imm_q  <= dec_imm_d;
                        skid_type_q <= dec_type_d;
                        skid_ill_q  <= dec_ill_d;
                        in_ready_q  <= 1'b0;
                        state_q     <= S_FULL;
                    end else if (pop) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (pop) begin
                        out_imm_q   <= skid_imm_q;
                        out_type_q  <= skid_type_q;
                        out_ill_q   <= skid_ill_q;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_ONE;
                    end
                end
                default: begin
                    state_q     <= S_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign imm_o       = out_imm_q;
    assign imm_type_o  = out_type_q;
    assign illegal_o   = out_ill_q;

endmodule
